// File: rtl/alu_arbiter.sv
// Two-port arbiter/sequencer sharing one pipelined 5-bit ALU between two requesters.
// Tags follow each issued op through the ALU latency and steer the result back to its owner.
module alu_arbiter #(
  parameter bit FIXED_PRIO = 1'b0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              hold,
  input  logic              req_valid_0,
  input  logic              req_valid_1,
  output logic              req_ready_0,
  output logic              req_ready_1,
  input  logic signed [4:0] req_a_0,
  input  logic signed [4:0] req_b_0,
  input  logic              req_a_en_0,
  input  logic [2:0]        req_a_op_0,
  input  logic              req_b_en_0,
  input  logic [1:0]        req_b_op_0,
  input  logic signed [4:0] req_a_1,
  input  logic signed [4:0] req_b_1,
  input  logic              req_a_en_1,
  input  logic [2:0]        req_a_op_1,
  input  logic              req_b_en_1,
  input  logic [1:0]        req_b_op_1,
  output logic              alu_en,
  output logic signed [4:0] alu_a,
  output logic signed [4:0] alu_b,
  output logic              alu_a_en,
  output logic [2:0]        alu_a_op,
  output logic              alu_b_en,
  output logic [1:0]        alu_b_op,
  input  logic              alu_c_en,
  input  logic signed [5:0] alu_c,
  output logic              resp_valid_0,
  output logic              resp_valid_1,
  output logic signed [5:0] resp_data,
  output logic              err_unexp,
  output logic              err_lost,
  output logic              busy
);

  typedef enum logic {RUN = 1'b0, DRAIN = 1'b1} state_t;

  state_t            state_q, state_d;
  logic [1:0]        cnt_q, cnt_d;
  logic              in_drain;
  logic              rr_q;
  logic              pick1, can_grant, gnt0, gnt1, xfer;
  logic              alu_en_q, alu_a_en_q, alu_b_en_q;
  logic signed [4:0] alu_a_q, alu_b_q;
  logic [2:0]        alu_a_op_q;
  logic [1:0]        alu_b_op_q;
  logic              tag_p0_q, tag_p1_q, tag_p2_q;
  logic              tag_vld_p1_q, tag_vld_p2_q;
  logic              resp_valid0_q, resp_valid1_q;
  logic signed [5:0] resp_data_q;
  logic              err_unexp_q, err_lost_q;
  logic              ret;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= DRAIN;
      cnt_q   <= 2'd3;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Drain covers the ALU latency so results launched before reset are discarded silently.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      DRAIN: begin
        cnt_d = cnt_q - 2'd1;
        if (cnt_q == 2'd1) state_d = RUN;
      end
      default: state_d = RUN;
    endcase
  end

  always_comb begin
    in_drain = (state_q == DRAIN);
  end

  always_comb begin
    pick1     = FIXED_PRIO ? 1'b0 : rr_q;
    can_grant = !rst && !in_drain && !hold;
    gnt0      = can_grant && req_valid_0 && (!req_valid_1 || !pick1);
    gnt1      = can_grant && req_valid_1 && (!req_valid_0 || pick1);
    xfer      = gnt0 || gnt1;
  end

  // Issue stage: operand/opcode registers hold when idle, alu_en is a single-cycle strobe.
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_q       <= 1'b0;
      alu_en_q   <= 1'b0;
      alu_a_q    <= '0;
      alu_b_q    <= '0;
      alu_a_en_q <= 1'b0;
      alu_a_op_q <= '0;
      alu_b_en_q <= 1'b0;
      alu_b_op_q <= '0;
    end else begin
      alu_en_q <= xfer;
      if (xfer) begin
        rr_q       <= gnt0;
        tag_p0_q   <= gnt1;
        alu_a_q    <= gnt1 ? req_a_1    : req_a_0;
        alu_b_q    <= gnt1 ? req_b_1    : req_b_0;
        alu_a_en_q <= gnt1 ? req_a_en_1 : req_a_en_0;
        alu_a_op_q <= gnt1 ? req_a_op_1 : req_a_op_0;
        alu_b_en_q <= gnt1 ? req_b_en_1 : req_b_en_0;
        alu_b_op_q <= gnt1 ? req_b_op_1 : req_b_op_0;
      end
    end
  end

  // Tag pipeline: stage p2 lines up with the cycle the ALU presents alu_c_en.
  always_ff @(posedge clk) begin
    tag_p1_q <= tag_p0_q;
    tag_p2_q <= tag_p1_q;
    if (rst) begin
      tag_vld_p1_q <= 1'b0;
      tag_vld_p2_q <= 1'b0;
    end else begin
      tag_vld_p1_q <= alu_en_q;
      tag_vld_p2_q <= tag_vld_p1_q;
    end
  end

  assign ret = tag_vld_p2_q && alu_c_en;

  // Return stage and sticky error flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      resp_valid0_q <= 1'b0;
      resp_valid1_q <= 1'b0;
      resp_data_q   <= '0;
      err_unexp_q   <= 1'b0;
      err_lost_q    <= 1'b0;
    end else begin
      resp_valid0_q <= ret && !tag_p2_q;
      resp_valid1_q <= ret && tag_p2_q;
      if (ret) resp_data_q <= alu_c;
      err_lost_q  <= err_lost_q || (tag_vld_p2_q && !alu_c_en);
      err_unexp_q <= err_unexp_q || (!tag_vld_p2_q && alu_c_en && !in_drain);
    end
  end

  assign req_ready_0  = gnt0;
  assign req_ready_1  = gnt1;
  assign alu_en       = alu_en_q;
  assign alu_a        = alu_a_q;
  assign alu_b        = alu_b_q;
  assign alu_a_en     = alu_a_en_q;
  assign alu_a_op     = alu_a_op_q;
  assign alu_b_en     = alu_b_en_q;
  assign alu_b_op     = alu_b_op_q;
  assign resp_valid_0 = resp_valid0_q;
  assign resp_valid_1 = resp_valid1_q;
  assign resp_data    = resp_data_q;
  assign err_unexp    = err_unexp_q;
  assign err_lost     = err_lost_q;
  assign busy         = alu_en_q || tag_vld_p1_q || tag_vld_p2_q ||
                        resp_valid0_q || resp_valid1_q || in_drain;

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter: drain, single ops, contention, hold, mid-op reset, error flags.
module tb_alu_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst, hold, v0, v1;
  logic signed [4:0] a0, b0, a1, b1;
  logic              a_en0, b_en0, a_en1, b_en1;
  logic [2:0]        a_op0, a_op1;
  logic [1:0]        b_op0, b_op1;
  int                inj;

  logic              r0, r1, alu_en, alu_a_en, alu_b_en;
  logic signed [4:0] alu_a, alu_b;
  logic [2:0]        alu_a_op;
  logic [1:0]        alu_b_op;
  logic              rv0, rv1, err_unexp, err_lost, busy;
  logic signed [5:0] resp_data;

  logic              fr0, fr1, f_en, f_aen, f_ben, f_rv0, f_rv1, f_eu, f_el, f_busy;
  logic signed [4:0] f_a, f_b;
  logic [2:0]        f_aop;
  logic [1:0]        f_bop;
  logic signed [5:0] f_rd;

  // Two-stage stand-in ALU (adds operands), not reset, so stale results survive a reset.
  logic              m_v1 = 1'b0, m_cen = 1'b0;
  logic signed [5:0] m_c1 = '0, m_c = '0;
  logic              c_en;
  always @(posedge clk) begin
    m_v1  <= alu_en;
    m_c1  <= {alu_a[4], alu_a} + {alu_b[4], alu_b};
    m_cen <= m_v1;
    m_c   <= m_c1;
  end
  assign c_en = (inj == 1) ? 1'b0 : (inj == 2) ? 1'b1 : m_cen;

  alu_arbiter #(.FIXED_PRIO(1'b0)) dut (
    .clk(clk), .rst(rst), .hold(hold),
    .req_valid_0(v0), .req_valid_1(v1), .req_ready_0(r0), .req_ready_1(r1),
    .req_a_0(a0), .req_b_0(b0), .req_a_en_0(a_en0), .req_a_op_0(a_op0),
    .req_b_en_0(b_en0), .req_b_op_0(b_op0),
    .req_a_1(a1), .req_b_1(b1), .req_a_en_1(a_en1), .req_a_op_1(a_op1),
    .req_b_en_1(b_en1), .req_b_op_1(b_op1),
    .alu_en(alu_en), .alu_a(alu_a), .alu_b(alu_b), .alu_a_en(alu_a_en),
    .alu_a_op(alu_a_op), .alu_b_en(alu_b_en), .alu_b_op(alu_b_op),
    .alu_c_en(c_en), .alu_c(m_c),
    .resp_valid_0(rv0), .resp_valid_1(rv1), .resp_data(resp_data),
    .err_unexp(err_unexp), .err_lost(err_lost), .busy(busy)
  );

  alu_arbiter #(.FIXED_PRIO(1'b1)) dut_fp (
    .clk(clk), .rst(rst), .hold(hold),
    .req_valid_0(v0), .req_valid_1(v1), .req_ready_0(fr0), .req_ready_1(fr1),
    .req_a_0(a0), .req_b_0(b0), .req_a_en_0(a_en0), .req_a_op_0(a_op0),
    .req_b_en_0(b_en0), .req_b_op_0(b_op0),
    .req_a_1(a1), .req_b_1(b1), .req_a_en_1(a_en1), .req_a_op_1(a_op1),
    .req_b_en_1(b_en1), .req_b_op_1(b_op1),
    .alu_en(f_en), .alu_a(f_a), .alu_b(f_b), .alu_a_en(f_aen),
    .alu_a_op(f_aop), .alu_b_en(f_ben), .alu_b_op(f_bop),
    .alu_c_en(c_en), .alu_c(m_c),
    .resp_valid_0(f_rv0), .resp_valid_1(f_rv1), .resp_data(f_rd),
    .err_unexp(f_eu), .err_lost(f_el), .busy(f_busy)
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; hold = 1'b0; inj = 0;
    v0 = 1'b1; a0 = 5'sd3; b0 = 5'sd2; a_en0 = 1'b1; a_op0 = 3'd0; b_en0 = 1'b0; b_op0 = 2'd0;
    v1 = 1'b0; a1 = 5'sd0; b1 = 5'sd0; a_en1 = 1'b0; a_op1 = 3'd5; b_en1 = 1'b1; b_op1 = 2'd2;
    tick(); tick();
    chk("rst_ready0", r0, 0);
    chk("rst_alu_en", alu_en, 0);
    chk("rst_alu_a", alu_a, 0);
    chk("rst_resp_valid0", rv0, 0);
    chk("rst_resp_data", resp_data, 0);
    chk("rst_err_lost", err_lost, 0);
    chk("rst_err_unexp", err_unexp, 0);
    chk("rst_busy", busy, 1);

    // Drain: three blocked cycles after reset release, then port 0 is granted.
    rst = 1'b0; #1;
    chk("drain0_ready0", r0, 0);
    tick(); chk("drain1_ready0", r0, 0);
    tick(); chk("drain2_ready0", r0, 0); chk("drain2_busy", busy, 1);
    tick(); chk("run_ready0", r0, 1); chk("run_ready1", r1, 0);
    chk("drain_err_lost", err_lost, 0); chk("drain_err_unexp", err_unexp, 0);

    // Single op on port 0: 3 + 2 = 5, response three cycles after acceptance.
    tick(); v0 = 1'b0;
    chk("single_alu_en", alu_en, 1); chk("single_alu_a", alu_a, 3); chk("single_alu_b", alu_b, 2);
    chk("single_alu_a_en", alu_a_en, 1); chk("single_alu_a_op", alu_a_op, 0);
    tick(); chk("single_rv0_early1", rv0, 0); chk("single_alu_en_off", alu_en, 0);
    tick(); chk("single_rv0_early2", rv0, 0);
    tick(); chk("single_rv0", rv0, 1); chk("single_data", resp_data, 5); chk("single_rv1", rv1, 0);
    tick(); chk("single_rv0_end", rv0, 0);

    // Solo op on port 1: -3 + -4 = -7, opcode fields pass through.
    a1 = -5'sd3; b1 = -5'sd4; v1 = 1'b1; #1;
    chk("solo1_ready1", r1, 1); chk("solo1_ready0", r0, 0);
    tick(); v1 = 1'b0;
    chk("solo1_alu_a", alu_a, -3); chk("solo1_a_op", alu_a_op, 5);
    chk("solo1_b_en", alu_b_en, 1); chk("solo1_b_op", alu_b_op, 2);
    tick(); tick(); tick();
    chk("solo1_rv1", rv1, 1); chk("solo1_data", resp_data, -7); chk("solo1_rv0", rv0, 0);
    tick();

    // Contention: both valid for four cycles.
    a0 = 5'sd4; b0 = 5'sd3; a1 = -5'sd8; b1 = -5'sd7; v0 = 1'b1; v1 = 1'b1; #1;
    chk("cont0_ready0", r0, 1); chk("cont0_ready1", r1, 0); chk("fp0_ready0", fr0, 1); chk("fp0_ready1", fr1, 0);
    tick(); chk("cont1_ready0", r0, 0); chk("cont1_ready1", r1, 1); chk("fp1_ready0", fr0, 1); chk("fp1_ready1", fr1, 0);
    tick(); chk("cont2_ready0", r0, 1); chk("cont2_ready1", r1, 0); chk("fp2_ready0", fr0, 1); chk("fp2_ready1", fr1, 0);
    tick(); chk("cont3_ready0", r0, 0); chk("cont3_ready1", r1, 1); chk("fp3_ready0", fr0, 1); chk("fp3_ready1", fr1, 0);
    tick(); v0 = 1'b0; v1 = 1'b0;
    chk("cresp0_rv0", rv0, 1); chk("cresp0_rv1", rv1, 0); chk("cresp0_data", resp_data, 7);
    tick(); chk("cresp1_rv1", rv1, 1); chk("cresp1_rv0", rv0, 0); chk("cresp1_data", resp_data, -15);
    tick(); chk("cresp2_rv0", rv0, 1); chk("cresp2_data", resp_data, 7);
    tick(); chk("cresp3_rv1", rv1, 1); chk("cresp3_data", resp_data, -15);
    tick(); chk("cresp_done_rv0", rv0, 0); chk("cresp_done_rv1", rv1, 0);

    // Hold with two ops in flight.
    v0 = 1'b1; v1 = 1'b1; #1;
    chk("hold_pre0_ready0", r0, 1);
    tick(); chk("hold_pre1_ready1", r1, 1);
    tick(); hold = 1'b1; #1;
    chk("hold_ready0", r0, 0); chk("hold_ready1", r1, 0); chk("hold_busy", busy, 1);
    tick(); chk("hold2_ready0", r0, 0); chk("hold2_ready1", r1, 0);
    tick(); chk("hold_resp0_rv0", rv0, 1); chk("hold_resp0_data", resp_data, 7);
    tick(); chk("hold_resp1_rv1", rv1, 1); chk("hold_resp1_data", resp_data, -15); chk("hold3_ready0", r0, 0);
    tick(); hold = 1'b0; #1;
    chk("unhold_ready0", r0, 1);
    tick(); v0 = 1'b0; v1 = 1'b0;
    chk("unhold_alu_en", alu_en, 1); chk("unhold_alu_a", alu_a, 4);
    tick(); tick(); tick();
    chk("unhold_rv0", rv0, 1); chk("unhold_data", resp_data, 7);
    tick(); chk("idle_busy", busy, 0);

    // Reset with two ops in flight: stale ALU results must be swallowed.
    v0 = 1'b1; v1 = 1'b1; #1;
    chk("mid_ready1", r1, 1);
    tick(); chk("mid_ready0", r0, 1);
    tick(); v0 = 1'b0; v1 = 1'b0; rst = 1'b1;
    tick(); rst = 1'b0;
    chk("mid_rv0_a", rv0, 0); chk("mid_rv1_a", rv1, 0); chk("mid_busy_a", busy, 1); chk("mid_alu_en", alu_en, 0);
    tick(); chk("mid_rv0_b", rv0, 0); chk("mid_rv1_b", rv1, 0); chk("mid_unexp_b", err_unexp, 0);
    tick(); chk("mid_unexp_c", err_unexp, 0); chk("mid_busy_c", busy, 1);
    tick(); chk("mid_busy_done", busy, 0); chk("mid_rv0_d", rv0, 0); chk("mid_rv1_d", rv1, 0);
    chk("mid_unexp_d", err_unexp, 0); chk("mid_lost_d", err_lost, 0);

    // Error injection: lost result, then unexpected result.
    a0 = 5'sd1; b0 = 5'sd1; v0 = 1'b1; #1;
    chk("inj_ready0", r0, 1);
    tick(); v0 = 1'b0; inj = 1;
    tick(); tick(); tick();
    chk("err_lost_set", err_lost, 1); chk("err_lost_no_resp", rv0, 0);
    tick(); inj = 0;
    tick(); chk("err_lost_sticky", err_lost, 1); chk("err_unexp_clear", err_unexp, 0);
    inj = 2;
    tick(); inj = 0;
    chk("err_unexp_set", err_unexp, 1);
    tick(); chk("err_unexp_sticky", err_unexp, 1); chk("err_lost_sticky2", err_lost, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Two-port round-robin arbiter and sequencer that shares the single 5-bit ALU datapath (`alu_design`) between two requesters. It accepts operation requests over a valid/ready handshake and drives the ALU operand and opcode inputs for one cycle per accepted request. It tracks which requester owns each in-flight operation and routes the registered ALU result back to that requester as a one-cycle response pulse. It sits between the command sources and the ALU instance, and is the only driver of the ALU's `ALU_en`/operand/opcode inputs.

## Interface
- `FIXED_PRIO`, default 0, meaning 1 = port 0 always wins and 0 = round-robin.
- `clk` input 1: single clock, rising edge.
- `rst` input 1: synchronous, active-high reset.
- `hold` input 1: when 1, no new request is granted; in-flight operations still complete.
- `req_valid_i` input 1 (i=0,1): request present.
- `req_ready_i` output 1 (i=0,1): grant; the transfer occurs when valid and ready are both 1 at a rising edge.
- `req_a_i`, `req_b_i` input 5 signed (i=0,1): operands.
- `req_a_en_i` input 1, `req_a_op_i` input 3, `req_b_en_i` input 1, `req_b_op_i` input 2 (i=0,1): opcode fields, passed through unmodified.
- `alu_en`, `alu_a`(5), `alu_b`(5), `alu_a_en`, `alu_a_op`(3), `alu_b_en`, `alu_b_op`(2): outputs to the ALU.
- `alu_c_en` input 1, `alu_c` input 6 signed: ALU outputs.
- `resp_valid_i` output 1 (i=0,1): one-cycle response pulse.
- `resp_data` output 6 signed: shared result bus, valid only while a `resp_valid_i` is high.
- `err_unexp` output 1: sticky; set when `alu_c_en`=1 arrives with no matching tag.
- `err_lost` output 1: sticky; set when a tag expects a result and `alu_c_en`=0.
- `busy` output 1: 1 while any operation is in flight or in drain.

## Operation
- **Grant logic**
  - `req_ready_i` is combinational from `req_valid_*`, `hold`, the rr pointer and the drain state. At most one ready is high per cycle.
  - Readies are 0 during reset, during drain, and while `hold`=1.
- **Round-robin**
  - Pointer `rr` (1 bit) names the preferred port; it resets to 0.
  - If only one port is valid, that port is granted.
  - If both ports are valid, port `rr` is granted.
  - After any accepted transfer, `rr` becomes the other port.
  - With `FIXED_PRIO`=1, port 0 always wins and `rr` is unused.
- **Issue**
  - On an accepted transfer, the `alu_*` registers load that port's fields and `alu_en`<=1 for exactly one cycle. A tag (port id) enters a 2-deep tag pipeline with its valid bit set.
  - With no transfer, `alu_en`<=0 and the operand/opcode registers hold their values.
  - Back-to-back issue (one per cycle) is supported; the ALU is fully pipelined.
- **Return**
  - When the tag pipeline's last stage is valid and `alu_c_en`=1: register `resp_data`<=`alu_c`, pulse `resp_valid_<tag>` for one cycle.
  - Responses have no backpressure; requesters must sink them.
- **Error checks**
  - Tag valid and `alu_c_en`=0 sets `err_lost`.
  - Tag invalid and `alu_c_en`=1 outside drain sets `err_unexp`.
  - Both flags clear only on `rst`.
- **Drain FSM** (states RUN and DRAIN)
  - `rst` forces DRAIN with a counter of 3.
  - In DRAIN: grants are blocked, `alu_c_en` is ignored (no error), and the counter decrements each cycle. Leave for RUN when the counter reaches 0.
  - Drain discards stale ALU results launched before reset; the ALU has its own separate asynchronous reset.
- **Arithmetic**
  - Operands and results pass through unmodified; no sign-extension or saturation is performed here.

## Timing
- **Reset values**
  - All `req_ready_i`=0, `alu_en`=0, `alu_*` fields=0.
  - `resp_valid_i`=0, `resp_data`=0, `err_*`=0.
  - `busy`=1 for the 3 drain cycles.
- **Latency**
  - Transfer at edge E0 → `alu_en`=1 during cycle E0..E1.
  - ALU registers the result at E1 and E2 → `alu_c_en`=1 during E2..E3.
  - `resp_valid_i`=1 during E3..E4.
  - Fixed 3-cycle request-to-response latency; responses return in issue order.
- **Simultaneous events**
  - Both ports valid every cycle: grants alternate 0,1,0,1 (rr mode).
  - `hold` rising mid-stream: no new grants; up to 2 in-flight results still return.
- **Reset mid-operation**
  - Tags clear and no responses are issued for in-flight operations.
  - The first grant is possible on the 4th cycle after `rst` deasserts.
- `busy` = tag pipeline any-valid OR `resp_valid` pending OR DRAIN.

## Test plan
- **Reset drain:** reset, then hold `req_valid_0`=1 → `req_ready_0`=0 for 3 cycles, then 1; no err flags.
- **Single op:** port0 A=3, B=2, `a_en`=1, `a_op`=0 → `resp_valid_0` pulses exactly 3 cycles after acceptance with `resp_data`=5; `resp_valid_1` stays 0.
- **Contention:**
  - Both ports valid for 4 cycles → grant order 0,1,0,1.
  - Responses arrive in that order, with the correct tag on each and consecutive pulses.
  - With `FIXED_PRIO`=1, port 0 takes all 4 grants.
- **Hold:** assert `hold` with 2 ops in flight → both responses still return and no new readies; deassert → issue resumes next cycle.
- **Mid-operation reset:** issue 2 ops, pulse `rst` one cycle later → no `resp_valid`, no `err_unexp` despite stale `alu_c_en`, `busy` clears after drain.
- **Error injection:**
  - Force `alu_c_en`=0 when a result is due → `err_lost`=1 and it stays set.
  - Force `alu_c_en`=1 while idle → `err_unexp`=1.
